// File: rtl/encode12.sv
// encode12 - Kyber 12-bit coefficient byte packer.
//
// Accepts pairs of coefficients (each < 2q), applies a final conditional
// subtraction of q, queues {last, k, idx, r1, r0} in a small pair FIFO and
// streams each pair out as three bytes with their byte address.
//
// Ports
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   set          : clock enable for every register
//   readin       : pair write strobe (accepted when set & readin_ok)
//   din_1/din_2  : even/odd coefficient, bits [12:0] used
//   in_index     : pair index within polynomial (0..127)
//   in_k         : polynomial index within vector (0..3)
//   full_in      : tags the written pair as the last of the transfer
//   readout      : byte consumed when set & output_ok
//   dout         : current byte (0 when idle)
//   out_index    : byte address of dout (0 when idle)
//   output_ok    : FIFO non-empty
//   readin_ok    : FIFO has room
//   done         : one-cycle pulse after the last byte of a tagged pair

module encode12_csub #(
  parameter int KQ = 3329
) (
  input  logic [12:0] i_din,
  output logic [11:0] o_r
);
  assign o_r = (i_din >= 13'(KQ)) ? 12'(i_din - 13'(KQ)) : i_din[11:0];
endmodule

module encode12 #(
  parameter int DEPTH = 4,
  parameter int KQ    = 3329
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        readin,
  input  logic [15:0] din_1,
  input  logic [15:0] din_2,
  input  logic [7:0]  in_index,
  input  logic [1:0]  in_k,
  input  logic        full_in,
  input  logic        readout,
  output logic [7:0]  dout,
  output logic [15:0] out_index,
  output logic        output_ok,
  output logic        readin_ok,
  output logic        done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        last;
    logic [1:0]  k;
    logic [7:0]  idx;
    logic [11:0] r1;
    logic [11:0] r0;
  } ent_t;

  typedef enum logic [1:0] {BYTE0 = 2'd0, BYTE1 = 2'd1, BYTE2 = 2'd2} bcnt_t;

  logic [1:0][12:0] w_din;
  logic [1:0][11:0] w_r;
  logic             w_unused;

  ent_t             r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt;
  bcnt_t            r_bcnt;
  logic             r_done;

  ent_t             w_head;
  logic             w_vld, w_rdy, w_wr, w_rd, w_pop;
  logic [7:0]       w_byte;

  assign w_din[0] = din_1[12:0];
  assign w_din[1] = din_2[12:0];
  assign w_unused = &{1'b0, din_1[15:13], din_2[15:13]};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_csub
      encode12_csub #(.KQ(KQ)) u_csub (.i_din(w_din[g]), .o_r(w_r[g]));
    end
  endgenerate

  assign w_head = r_mem[r_rptr];
  assign w_vld  = (r_cnt != '0);
  assign w_rdy  = (r_cnt < CNT_FULL);
  assign w_wr   = set & readin & w_rdy;
  assign w_rd   = set & readout & w_vld;
  assign w_pop  = w_rd & (r_bcnt == BYTE2);

  // Storage needs no reset: validity is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {full_in, in_k, in_index, w_r[1], w_r[0]};
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_bcnt <= BYTE0;
      r_done <= 1'b0;
    end else if (set) begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_rd) r_bcnt <= (r_bcnt == BYTE2) ? BYTE0 : bcnt_t'(r_bcnt + 2'd1);
      r_done <= w_pop & w_head.last;
    end
  end

  always_comb begin
    w_byte = '0;
    if (w_vld) begin
      case (r_bcnt)
        BYTE0:   w_byte = w_head.r0[7:0];
        BYTE1:   w_byte = {w_head.r1[3:0], w_head.r0[11:8]};
        default: w_byte = w_head.r1[11:4];
      endcase
    end
  end

  assign dout      = w_byte;
  assign out_index = w_vld ? (16'(w_head.k) * 16'd384 + 16'(w_head.idx) * 16'd3 + 16'(r_bcnt))
                           : 16'd0;
  assign output_ok = w_vld;
  assign readin_ok = w_rdy;
  assign done      = r_done;

endmodule

// File: tb/tb_encode12.sv
module tb_encode12;
  logic        clk = 1'b0;
  logic        reset, set, readin, full_in, readout;
  logic [15:0] din_1, din_2;
  logic [7:0]  in_index;
  logic [1:0]  in_k;
  logic [7:0]  dout;
  logic [15:0] out_index;
  logic        output_ok, readin_ok, done;

  encode12 #(.DEPTH(4), .KQ(3329)) dut (
    .clk(clk), .reset(reset), .set(set), .readin(readin),
    .din_1(din_1), .din_2(din_2), .in_index(in_index), .in_k(in_k),
    .full_in(full_in), .readout(readout), .dout(dout), .out_index(out_index),
    .output_ok(output_ok), .readin_ok(readin_ok), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic [15:0] ix;
    bit          dn;
  } exp_t;

  exp_t q[$];
  int   m_cnt = 0;
  bit   exp_done = 0;
  bit   mon_en = 0;
  int   n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] csub(input logic [15:0] v);
    logic [12:0] t;
    t = v[12:0];
    return (t >= 13'd3329) ? 12'(t - 13'd3329) : t[11:0];
  endfunction

  function automatic void push_pair(input logic [15:0] c0, input logic [15:0] c1,
                                    input int k, input int idx, input bit last);
    logic [11:0] a, b;
    logic [15:0] base;
    a = csub(c0);
    b = csub(c1);
    base = 16'(k * 384 + idx * 3);
    q.push_back('{a[7:0], base, 1'b0});
    q.push_back('{{b[3:0], a[11:8]}, base + 16'd1, 1'b0});
    q.push_back('{b[11:4], base + 16'd2, last});
  endfunction

  // Reference model: byte queue plus pair count, checked every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      automatic bit nd = 0;
      automatic int c0 = m_cnt;
      chk("done", done, exp_done);
      chk("output_ok", output_ok, q.size() != 0);
      chk("readin_ok", readin_ok, c0 < 4);
      if (q.size() != 0) begin
        chk("dout", dout, q[0].d);
        chk("out_index", out_index, q[0].ix);
      end else begin
        chk("dout_idle", dout, 0);
        chk("out_index_idle", out_index, 0);
      end
      if (set && readout && q.size() != 0) begin
        nd = q[0].dn;
        if (q.size() % 3 == 1) m_cnt--;
        void'(q.pop_front());
      end
      if (set && readin && c0 < 4) begin
        push_pair(din_1, din_2, in_k, in_index, full_in);
        m_cnt++;
      end
      if (set) exp_done = nd;
    end
  end

  task automatic wr(input logic [15:0] c0, input logic [15:0] c1,
                    input logic [1:0] k, input logic [7:0] idx, input logic last);
    din_1 = c0; din_2 = c1; in_k = k; in_index = idx; full_in = last;
    readin = 1'b1;
    @(posedge clk); #1;
    readin = 1'b0; full_in = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    q.delete();
    m_cnt = 0;
    exp_done = 0;
    mon_en = 1;
  endtask

  initial begin
    reset = 1'b1; set = 1'b1; readin = 1'b0; full_in = 1'b0; readout = 1'b0;
    din_1 = '0; din_2 = '0; in_index = '0; in_k = '0;
    cyc(1);
    do_reset();
    cyc(1);

    // single pair, tagged last
    readout = 1'b1;
    wr(16'h123, 16'h456, 2'd0, 8'd0, 1'b1);
    cyc(6);

    // conditional subtraction and address
    wr(16'd3329, 16'd6657, 2'd2, 8'd127, 1'b0);
    cyc(5);

    // backpressure: 5th write must be dropped
    readout = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr(16'(100 * i + 7), 16'(3329 + 500 * i), 2'd0, 8'(i), 1'b0);
      if (i == 3) chk("bp_full", readin_ok, 0);
    end
    for (int i = 0; i < 24; i++) begin
      readout = ~readout;
      cyc(1);
    end
    readout = 1'b0;
    cyc(2);

    // stall mid-pair, then write in the cycle BYTE2 is popped
    wr(16'h0ABC, 16'h0123, 2'd3, 8'd10, 1'b1);
    wr(16'h1FFF, 16'h0D01, 2'd1, 8'd20, 1'b0);
    readout = 1'b1;
    cyc(1);
    set = 1'b0;
    cyc(3);
    set = 1'b1;
    cyc(1);
    wr(16'h0777, 16'h0888, 2'd1, 8'd21, 1'b1);
    chk("simul_rdy", readin_ok, 1);
    cyc(12);

    // reset after BYTE1 of a tagged pair
    readout = 1'b0;
    wr(16'h0F0F, 16'h0A5A, 2'd0, 8'd5, 1'b1);
    readout = 1'b1;
    cyc(2);
    do_reset();
    wr(16'h0321, 16'h0654, 2'd1, 8'd3, 1'b0);
    cyc(6);

    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
